briham_scan_controller: RTL

- Sequencer for the 4-bit combinational code detector: drives the detector's 4-bit code input and samples its single hit output.
- Manual mode: the code follows debounced board switches and the hit is shown on the LED.
- Sweep mode: on start, walks codes 0..15 with a visible dwell per code, building a 16-bit hit map and a hit count for board self-test.
- Sits between switches/buttons and the detector instance; the detector is instantiated externally.

---
 rtl/briham_pkg.sv | 16 +
 rtl/briham_debounce.sv | 42 ++++
 rtl/briham_scan_controller.sv | 116 +++++++++++
 3 files changed

// File: rtl/briham_pkg.sv
// Shared types and constants for the briham code-detector scan controller.
package briham_pkg;

  localparam int unsigned CODE_W    = 4;
  localparam int unsigned NUM_CODES = 16;
  localparam int unsigned COUNT_W   = 5;

  typedef enum logic [2:0] {
    StIdle,
    StSettle,
    StSample,
    StDwell,
    StDone
  } state_e;

endpackage

// File: rtl/briham_debounce.sv
// Two-flop synchroniser plus stability counter for the 4 board switches.
module briham_debounce
  import briham_pkg::*;
#(
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] sw,
  output logic [CODE_W-1:0] sw_db
);

  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);

  logic [CODE_W-1:0] sync1_q, sync2_q, cand_q, db_q;
  logic [DbW-1:0]    cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '0;
      db_q    <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sw;
      sync2_q <= sync1_q;
      if (sync2_q != cand_q) begin
        cand_q <= sync2_q;
        cnt_q  <= '0;
      end else if (cnt_q == DbW'(DB_CYCLES - 1)) begin
        // Counter parks here; the accepted value is refreshed every stable cycle.
        db_q <= cand_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign sw_db = db_q;

endmodule

// File: rtl/briham_scan_controller.sv
// Drives the external 4-bit code detector: manual switch mode or a 0..15 sweep building a hit map.
module briham_scan_controller
  import briham_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 25_000_000,
  parameter int unsigned DB_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CODE_W-1:0]  sw,
  input  logic               mode,
  input  logic               start,
  input  logic               det_hit,
  output logic [CODE_W-1:0]  code,
  output logic               led,
  output logic               busy,
  output logic               done,
  output logic [COUNT_W-1:0] hit_count,
  output logic [NUM_CODES-1:0] hit_map
);

  localparam int unsigned TickW = $clog2(TICK_DIV + 1);

  logic [CODE_W-1:0]    sw_db;
  state_e               state_q, state_d;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 led_q, led_d;
  logic                 busy_q, busy_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [NUM_CODES-1:0] map_q, map_d;
  logic [TickW-1:0]     tick_q, tick_d;

  briham_debounce #(
    .DB_CYCLES(DB_CYCLES)
  ) u_debounce (
    .clk  (clk),
    .rst_n(rst_n),
    .sw   (sw),
    .sw_db(sw_db)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      code_q  <= '0;
      led_q   <= 1'b0;
      busy_q  <= 1'b0;
      count_q <= '0;
      map_q   <= '0;
      tick_q  <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      led_q   <= led_d;
      busy_q  <= busy_d;
      count_q <= count_d;
      map_q   <= map_d;
      tick_q  <= tick_d;
    end
  end

  always_comb begin
    state_d = state_q;
    code_d  = code_q;
    led_d   = led_q;
    busy_d  = busy_q;
    count_d = count_q;
    map_d   = map_q;
    tick_d  = tick_q;
    unique case (state_q)
      StIdle: begin
        code_d = sw_db;
        led_d  = det_hit;
        if (start && mode) begin
          map_d   = '0;
          count_d = '0;
          code_d  = '0;
          busy_d  = 1'b1;
          state_d = StSettle;
        end
      end
      StSettle: state_d = StSample;
      StSample: begin
        map_d[code_q] = det_hit;
        count_d       = count_q + COUNT_W'(det_hit);
        led_d         = det_hit;
        tick_d        = TickW'(TICK_DIV - 1);
        state_d       = StDwell;
      end
      StDwell: begin
        if (tick_q == '0) begin
          if (code_q == CODE_W'(NUM_CODES - 1)) begin
            // busy drops as DONE is entered so it covers exactly the 16 code slots.
            busy_d  = 1'b0;
            state_d = StDone;
          end else begin
            code_d  = code_q + 1'b1;
            state_d = StSettle;
          end
        end else begin
          tick_d = tick_q - 1'b1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign code      = code_q;
  assign led       = led_q;
  assign busy      = busy_q;
  assign done      = (state_q == StDone);
  assign hit_count = count_q;
  assign hit_map   = map_q;

endmodule
